// File: rtl/serial_subtractor_if.sv
// Operation handshake and result bus between a controller and serial_subtractor.
// The controller drives start/operands; the subtractor returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor step per clock.
// Start/busy/done handshake; all outputs come straight from flops.
module serial_subtractor #(
  parameter int WIDTH = 8  // must be >= 2
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic accept;
  logic step;
  logic finish;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] part;
  logic [CW-1:0]    cnt;
  logic             borrow;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  // Full subtractor as two half-subtractor stages on the current LSBs.
  logic x, y, c;
  logic d1, b1, dbit, b2, borrow_n;

  always_comb begin
    x        = a_sh[0];
    y        = b_sh[0];
    c        = borrow;
    d1       = x ^ y;
    b1       = ~x & y;
    dbit     = d1 ^ c;
    b2       = ~d1 & c;
    borrow_n = b1 | b2;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == S_RUN);
      done_q <= (state_n == S_DONE);
    end
  end

  // NOTE: the datapath flops are reset too, so an aborted run leaves no stale partial state behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      part   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        borrow <= bus.bin;
        cnt    <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        borrow <= borrow_n;
        // Shift in from the top; the last bit goes straight to diff, so part is one bit short.
        part   <= (WIDTH-1)'({dbit, part} >> 1);
        cnt    <= cnt + CW'(1);
      end

      // On the final edge the operand LSBs are the original sign bits.
      if (finish) begin
        diff_q <= {dbit, part};
        bout_q <= borrow_n;
        ovf_q  <= (x != y) && (dbit != x);
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at issue
// and compared whenever done pulses; handshake timing checked alongside.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } result_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  result_t exp_q[$];

  int ncyc          = 0;
  int busy_len      = 0;
  int last_busy_len = 0;
  int done_cnt      = 0;
  int done_cyc      = 0;
  int prev_done_cyc = 0;
  int start_cyc     = 0;

  logic [W-1:0] ta [5] = '{8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [W-1:0] tb [5] = '{8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF};
  logic         tbi[5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    result_t    r;
    full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    r.diff = full[W-1:0];
    r.bout = full[W];
    r.ovf  = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    result_t e;
    ncyc++;
    if (bus.busy) busy_len++;
    if (bus.done) begin
      prev_done_cyc = done_cyc;
      done_cyc      = ncyc;
      last_busy_len = busy_len;
      busy_len      = 0;
      done_cnt++;
      check("busy_in_done", bus.busy, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", bus.done, 0);
      end else begin
        e = exp_q.pop_front();
        check("diff", bus.diff, e.diff);
        check("bout", bus.bout, e.bout);
        check("ovf",  bus.ovf,  e.ovf);
      end
    end
  end

  // One-cycle start pulse; operands are scrambled afterwards to show they are sampled once.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit push);
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    if (push) exp_q.push_back(model(a, b, bin));
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    @(negedge clk); #1;
    start_cyc = ncyc;
  endtask

  task automatic pulse_ignored();
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.bin   = 1'b0;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_timeout", 32'(done_cnt >= target), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    result_t prev;
    int      d0;

    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.bin   = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf",  bus.ovf,  0);
    bus.start = 1'b0;
    rst_n     = 1'b1;

    // Basic operation with latency and busy-length checks.
    busy_len = 0;
    d0 = done_cnt;
    issue(8'h05, 8'h03, 1'b0, 1'b1);
    wait_done(d0 + 1, 20);
    check("latency",  done_cyc - start_cyc, W);
    check("busy_len", last_busy_len, W);
    prev = model(8'h05, 8'h03, 1'b0);

    // Sign/borrow corner cases; the previous result must hold through each run.
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      issue(ta[i], tb[i], tbi[i], 1'b1);
      repeat (3) @(negedge clk);
      #1;
      check("hold_diff", bus.diff, prev.diff);
      check("hold_bout", bus.bout, prev.bout);
      wait_done(d0 + 1, 20);
      prev = model(ta[i], tb[i], tbi[i]);
    end

    // Starts while busy must be ignored.
    d0 = done_cnt;
    issue(8'h10, 8'h01, 1'b0, 1'b1);
    pulse_ignored();
    @(posedge clk);
    pulse_ignored();
    wait_done(d0 + 1, 20);
    repeat (12) @(negedge clk);
    #1;
    check("ignored_done_count", done_cnt, d0 + 1);
    check("ignored_queue_empty", exp_q.size(), 0);

    // Back-to-back: start held through the DONE cycle of the first run.
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.a     = 8'h09;
    bus.b     = 8'h04;
    bus.bin   = 1'b0;
    exp_q.push_back(model(8'h09, 8'h04, 1'b0));
    exp_q.push_back(model(8'h20, 8'h30, 1'b0));
    d0 = done_cnt;
    @(posedge clk); #2;
    bus.a = 8'h20;
    bus.b = 8'h30;
    wait_done(d0 + 1, 20);
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done(d0 + 2, 20);
    // One DONE cycle separates the W run cycles of consecutive operations.
    check("b2b_spacing",  done_cyc - prev_done_cyc, W + 1);
    check("b2b_busy_len", last_busy_len, W);

    // Reset in the middle of a run aborts it.
    d0 = done_cnt;
    issue(8'h40, 8'h01, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_diff", bus.diff, 0);
    check("abort_bout", bus.bout, 0);
    check("abort_ovf",  bus.ovf,  0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    issue(8'h02, 8'h01, 1'b0, 1'b1);
    wait_done(d0 + 1, 20);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
